// File: rtl/lsu_rmw_sequencer.sv
// LSU data-memory sequencer: loads and word stores pass through, byte/half stores become read-modify-write.
// Optional feature macro RMW_ERR_ABORT_EN: a read-phase bus error aborts the RMW before its write.
module lsu_rmw_sequencer #(
  parameter int ADD_WIDTH = 32,
  parameter int DAT_WIDTH = 32
) (
  input  logic                 s_clk_i,
  input  logic                 s_resetn_i,
  input  logic                 s_req_val_i,
  output logic                 s_req_rdy_o,
  input  logic [ADD_WIDTH-1:0] s_req_add_i,
  input  logic                 s_req_we_i,
  input  logic [1:0]           s_req_size_i,
  input  logic [DAT_WIDTH-1:0] s_req_wdata_i,
  output logic                 s_rsp_val_o,
  output logic [DAT_WIDTH-1:0] s_rsp_rdata_o,
  output logic                 s_rsp_err_o,
  output logic                 s_mem_req_o,
  input  logic                 s_mem_gnt_i,
  output logic [ADD_WIDTH-1:0] s_mem_add_o,
  output logic                 s_mem_we_o,
  output logic [DAT_WIDTH-1:0] s_mem_wdata_o,
  input  logic                 s_mem_rvalid_i,
  input  logic [DAT_WIDTH-1:0] s_mem_rdata_i,
  input  logic                 s_mem_err_i,
  output logic [1:0]           s_rmw_state_o
);

  // Encoding matches the LSU_RMW_* state values so word-ECC memories never see partial writes.
  typedef enum logic [1:0] {
    LSU_RMW_IDLE  = 2'b00,
    LSU_RMW_READ  = 2'b01,
    LSU_RMW_WRITE = 2'b10,
    LSU_RMW_PASS  = 2'b11
  } rmw_state_e;

  function automatic logic [3:0] f_lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    f_lane_mask = 4'b0001 << off;
      2'd1:    f_lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: f_lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DAT_WIDTH-1:0] f_align_wdata(input logic [1:0] size,
                                                         input logic [DAT_WIDTH-1:0] wdata);
    case (size)
      2'd0:    f_align_wdata = {4{wdata[7:0]}};
      2'd1:    f_align_wdata = {2{wdata[15:0]}};
      default: f_align_wdata = wdata;
    endcase
  endfunction

  function automatic logic [DAT_WIDTH-1:0] f_merge(input logic [DAT_WIDTH-1:0] old_w,
                                                   input logic [DAT_WIDTH-1:0] new_w,
                                                   input logic [3:0]           mask);
    for (int i = 0; i < 4; i++) begin
      f_merge[i*8 +: 8] = mask[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    end
  endfunction

  rmw_state_e           r_state, w_state_nxt;
  logic                 r_mem_req, w_mem_req_nxt;
  logic                 r_mem_we, w_mem_we_nxt;
  logic [ADD_WIDTH-1:0] r_mem_add, w_mem_add_nxt;
  logic [DAT_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]           r_mask, w_mask_nxt;
  logic                 r_wait, w_wait_nxt;
  logic                 r_rd_err, w_rd_err_nxt;
  logic                 r_rsp_val, w_rsp_val_nxt;
  logic [DAT_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                 r_rsp_err, w_rsp_err_nxt;

  logic                 w_accept;
  logic                 w_misal;
  logic                 w_rmw;
  logic                 w_gnt;
  logic                 w_done;
  logic [DAT_WIDTH-1:0] w_merged;

  assign s_req_rdy_o = (r_state == LSU_RMW_IDLE) & ~r_rsp_val;
  assign w_accept    = s_req_val_i & s_req_rdy_o;
  assign w_misal     = ((s_req_size_i == 2'd1) & s_req_add_i[0]) |
                       (s_req_size_i[1] & (s_req_add_i[1:0] != 2'b00));
  assign w_rmw       = s_req_we_i & ~s_req_size_i[1];
  // A grant only counts while requesting, and rvalid only after a grant.
  assign w_gnt       = r_mem_req & s_mem_gnt_i;
  assign w_done      = r_wait & s_mem_rvalid_i;
  assign w_merged    = f_merge(s_mem_rdata_i, r_mem_wdata, r_mask);

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_add_nxt   = r_mem_add;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mask_nxt      = r_mask;
    w_wait_nxt      = r_wait;
    w_rd_err_nxt    = r_rd_err;
    w_rsp_val_nxt   = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      LSU_RMW_IDLE: begin
        if (w_accept) begin
          if (w_misal) begin
            w_rsp_val_nxt   = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = {DAT_WIDTH{1'b0}};
          end else begin
            w_mem_req_nxt = 1'b1;
            w_mem_add_nxt = {s_req_add_i[ADD_WIDTH-1:2], 2'b00};
            w_mask_nxt    = f_lane_mask(s_req_size_i, s_req_add_i[1:0]);
            w_rd_err_nxt  = 1'b0;
            w_wait_nxt    = 1'b0;
            if (w_rmw) begin
              w_state_nxt     = LSU_RMW_READ;
              w_mem_we_nxt    = 1'b0;
              w_mem_wdata_nxt = f_align_wdata(s_req_size_i, s_req_wdata_i);
            end else begin
              w_state_nxt     = LSU_RMW_PASS;
              w_mem_we_nxt    = s_req_we_i;
              w_mem_wdata_nxt = s_req_we_i ? s_req_wdata_i : {DAT_WIDTH{1'b0}};
            end
          end
        end else begin
          w_wait_nxt = 1'b0;
        end
      end
      LSU_RMW_PASS: begin
        if (w_gnt) begin
          w_mem_req_nxt = 1'b0;
          w_wait_nxt    = 1'b1;
        end else if (w_done) begin
          w_wait_nxt      = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_state_nxt     = LSU_RMW_IDLE;
          w_rsp_val_nxt   = 1'b1;
          w_rsp_rdata_nxt = s_mem_rdata_i;
          w_rsp_err_nxt   = s_mem_err_i;
        end else begin
          w_state_nxt = LSU_RMW_PASS;
        end
      end
      LSU_RMW_READ: begin
        if (w_gnt) begin
          w_mem_req_nxt = 1'b0;
          w_wait_nxt    = 1'b1;
        end else if (w_done) begin
          w_wait_nxt   = 1'b0;
          w_rd_err_nxt = s_mem_err_i;
`ifdef RMW_ERR_ABORT_EN
          if (s_mem_err_i) begin
            w_state_nxt     = LSU_RMW_IDLE;
            w_rsp_val_nxt   = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = {DAT_WIDTH{1'b0}};
          end else begin
            w_state_nxt     = LSU_RMW_WRITE;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = 1'b1;
            w_mem_wdata_nxt = w_merged;
          end
`else
          w_state_nxt     = LSU_RMW_WRITE;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b1;
          w_mem_wdata_nxt = w_merged;
`endif
        end else begin
          w_state_nxt = LSU_RMW_READ;
        end
      end
      LSU_RMW_WRITE: begin
        if (w_gnt) begin
          w_mem_req_nxt = 1'b0;
          w_wait_nxt    = 1'b1;
        end else if (w_done) begin
          w_wait_nxt      = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_state_nxt     = LSU_RMW_IDLE;
          w_rsp_val_nxt   = 1'b1;
          w_rsp_rdata_nxt = {DAT_WIDTH{1'b0}};
          w_rsp_err_nxt   = s_mem_err_i | r_rd_err;
        end else begin
          w_state_nxt = LSU_RMW_WRITE;
        end
      end
      default: begin
        w_state_nxt   = LSU_RMW_IDLE;
        w_mem_req_nxt = 1'b0;
        w_wait_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_state     <= LSU_RMW_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_add   <= {ADD_WIDTH{1'b0}};
      r_mem_wdata <= {DAT_WIDTH{1'b0}};
      r_mask      <= 4'b0000;
      r_wait      <= 1'b0;
      r_rd_err    <= 1'b0;
      r_rsp_val   <= 1'b0;
      r_rsp_rdata <= {DAT_WIDTH{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_add   <= w_mem_add_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mask      <= w_mask_nxt;
      r_wait      <= w_wait_nxt;
      r_rd_err    <= w_rd_err_nxt;
      r_rsp_val   <= w_rsp_val_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign s_rsp_val_o   = r_rsp_val;
  assign s_rsp_rdata_o = r_rsp_rdata;
  assign s_rsp_err_o   = r_rsp_err;
  assign s_mem_req_o   = r_mem_req;
  assign s_mem_add_o   = r_mem_add;
  assign s_mem_we_o    = r_mem_we;
  assign s_mem_wdata_o = r_mem_wdata;
  assign s_rmw_state_o = r_state;

endmodule

// File: tb/tb_lsu_rmw_sequencer.sv
// Scoreboard bench for lsu_rmw_sequencer with a behavioural word memory and grant-delay/error knobs.
module tb_lsu_rmw_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic [31:0] req_add = 32'h0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_val;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_add;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_err = 1'b0;
  logic [1:0]  rmw_state;

  lsu_rmw_sequencer dut (
    .s_clk_i(clk), .s_resetn_i(rst_n),
    .s_req_val_i(req_val), .s_req_rdy_o(req_rdy), .s_req_add_i(req_add),
    .s_req_we_i(req_we), .s_req_size_i(req_size), .s_req_wdata_i(req_wdata),
    .s_rsp_val_o(rsp_val), .s_rsp_rdata_o(rsp_rdata), .s_rsp_err_o(rsp_err),
    .s_mem_req_o(mem_req), .s_mem_gnt_i(mem_gnt), .s_mem_add_o(mem_add),
    .s_mem_we_o(mem_we), .s_mem_wdata_o(mem_wdata), .s_mem_rvalid_i(mem_rvalid),
    .s_mem_rdata_i(mem_rdata), .s_mem_err_i(mem_err), .s_rmw_state_o(rmw_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit [31:0]   mem [bit [31:0]];
  int          gnt_delay = 0;
  int          gnt_wait = 0;
  bit          pend_valid = 1'b0;
  logic [31:0] pend_rdata = 32'h0;
  logic        pend_err = 1'b0;
  bit          inj_read_err = 1'b0;
  bit          stray = 1'b0;
  int          reads = 0;
  int          writes = 0;
  logic [31:0] h_add, h_wdata;
  logic        h_we;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: grants after gnt_delay cycles of held request, rvalid one cycle after grant.
  always @(negedge clk) begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_err = 1'b0;
    if (!rst_n) begin
      pend_valid = 1'b0;
      gnt_wait = 0;
    end else if (stray) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'h0BAD0BAD;
      stray = 1'b0;
    end else if (pend_valid) begin
      mem_rvalid = 1'b1;
      mem_rdata = pend_rdata;
      mem_err = pend_err;
      pend_valid = 1'b0;
    end else if (mem_req) begin
      if (gnt_wait == 0) begin
        h_add = mem_add; h_we = mem_we; h_wdata = mem_wdata;
      end else begin
        check_eq("req_add_stable", mem_add, h_add);
        check_eq("req_we_stable", {31'd0, mem_we}, {31'd0, h_we});
        check_eq("req_wdata_stable", mem_wdata, h_wdata);
      end
      if (gnt_wait < gnt_delay) begin
        gnt_wait++;
      end else begin
        mem_gnt = 1'b1;
        gnt_wait = 0;
        pend_valid = 1'b1;
        if (mem_we) begin
          mem[mem_add] = mem_wdata;
          writes++;
          pend_rdata = 32'h0;
          pend_err = 1'b0;
        end else begin
          reads++;
          pend_rdata = mem[mem_add];
          pend_err = inj_read_err;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (rst_n && rsp_val) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        check_eq("rsp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] add,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input bit expect_rsp);
    int t;
    exp_t e;
    @(negedge clk);
    t = 0;
    while (!req_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_rdy) begin
      check_eq("req_rdy_timeout", 32'd0, 32'd1);
    end else begin
      req_val = 1'b1; req_we = we; req_size = size; req_add = add; req_wdata = wdata;
      if (expect_rsp) begin
        e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
        sb.push_back(e);
      end
      @(negedge clk);
      req_val = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain", sb.size(), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic clr_cnt();
    reads = 0;
    writes = 0;
  endtask

  initial begin
    mem[32'h104] = 32'hDEADBEEF;
    mem[32'h200] = 32'h11223344;
    mem[32'h300] = 32'h11223344;
    mem[32'h600] = 32'h01020304;
    mem[32'h700] = 32'hFFFFFFFF;
    mem[32'h800] = 32'h55AA55AA;
    repeat (3) @(negedge clk);
    check_eq("rst_rdy", {31'd0, req_rdy}, 32'd1);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_rsp_val", {31'd0, rsp_val}, 32'd0);
    check_eq("rst_state", {30'd0, rmw_state}, 32'd0);
    rst_n = 1'b1;

    clr_cnt();
    do_req(1'b0, 2'd2, 32'h104, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
    drain();
    check_eq("load_reads", reads, 32'd1);
    check_eq("load_writes", writes, 32'd0);

    clr_cnt();
    do_req(1'b0, 2'd0, 32'h105, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
    drain();

    clr_cnt();
    do_req(1'b1, 2'd0, 32'h203, 32'h000000AB, 32'h0, 1'b0, 5, 1'b1);
    drain();
    check_eq("byte_store_mem", mem[32'h200], 32'hAB223344);
    check_eq("byte_store_acc", reads * 10 + writes, 32'd11);

    clr_cnt();
    gnt_delay = 3;
    do_req(1'b1, 2'd1, 32'h302, 32'h0000BEEF, 32'h0, 1'b0, 11, 1'b1);
    drain();
    gnt_delay = 0;
    check_eq("half_store_mem", mem[32'h300], 32'hBEEF3344);

    clr_cnt();
    do_req(1'b1, 2'd1, 32'h401, 32'h1234, 32'h0, 1'b1, 1, 1'b1);
    drain();
    check_eq("misal_no_access", reads + writes, 32'd0);
    check_eq("misal_rdy_back", {31'd0, req_rdy}, 32'd1);

    clr_cnt();
    do_req(1'b0, 2'd2, 32'h902, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    drain();
    check_eq("misal_word_no_access", reads + writes, 32'd0);

    clr_cnt();
    do_req(1'b1, 2'd2, 32'h500, 32'hCAFEF00D, 32'h0, 1'b0, 3, 1'b1);
    drain();
    check_eq("word_store_mem", mem[32'h500], 32'hCAFEF00D);
    check_eq("word_store_acc", reads * 10 + writes, 32'd1);

    clr_cnt();
    do_req(1'b1, 2'd1, 32'h700, 32'h00001234, 32'h0, 1'b0, 5, 1'b1);
    drain();
    check_eq("half_low_mem", mem[32'h700], 32'hFFFF1234);

    clr_cnt();
    inj_read_err = 1'b1;
`ifdef RMW_ERR_ABORT_EN
    do_req(1'b1, 2'd0, 32'h601, 32'h0000005A, 32'h0, 1'b1, 3, 1'b1);
    drain();
    check_eq("rd_err_mem", mem[32'h600], 32'h01020304);
    check_eq("rd_err_writes", writes, 32'd0);
`else
    do_req(1'b1, 2'd0, 32'h601, 32'h0000005A, 32'h0, 1'b1, 5, 1'b1);
    drain();
    check_eq("rd_err_mem", mem[32'h600], 32'h01025A04);
    check_eq("rd_err_writes", writes, 32'd1);
`endif
    do_req(1'b0, 2'd2, 32'h800, 32'h0, 32'h55AA55AA, 1'b1, 3, 1'b1);
    drain();
    inj_read_err = 1'b0;

    stray = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("stray_state", {30'd0, rmw_state}, 32'd0);
    check_eq("stray_rdy", {31'd0, req_rdy}, 32'd1);

    clr_cnt();
    mem[32'hA00] = 32'h89ABCDEF;
    gnt_delay = 10;
    do_req(1'b1, 2'd0, 32'hA02, 32'h00000077, 32'h0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 100 && rmw_state != 2'd2; i++) @(negedge clk);
    check_eq("reach_write", {30'd0, rmw_state}, 32'd2);
    check_eq("write_req_high", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("midrst_state", {30'd0, rmw_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gnt_delay = 0;
    repeat (20) @(negedge clk);
    check_eq("midrst_writes", writes, 32'd0);
    check_eq("midrst_mem", mem[32'hA00], 32'h89ABCDEF);
    check_eq("midrst_rdy", {31'd0, req_rdy}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
